// File: rtl/levinson_update_if.sv
// Handshake, datapath-stage and read-port bundle for levinson_update.
interface levinson_update_if #(parameter int IW = 4);
  logic          clear;
  logic          start;
  logic [IW-1:0] order_i;
  logic [31:0]   k;
  logic          busy;
  logic          done;
  logic          err;
  logic          lo_out_sel;
  logic [31:0]   lo_temp;
  logic [31:0]   lo_a;
  logic [31:0]   lo_k;
  logic [31:0]   lo_next_a;
  logic [IW-1:0] rd_idx;
  logic [31:0]   rd_coef;

  modport slave (
    input  clear, start, order_i, k, lo_next_a, rd_idx,
    output busy, done, err, lo_out_sel, lo_temp, lo_a, lo_k, rd_coef
  );
  modport master (
    output clear, start, order_i, k, lo_next_a, rd_idx,
    input  busy, done, err, lo_out_sel, lo_temp, lo_a, lo_k, rd_coef
  );
endinterface

// File: rtl/levinson_update.sv
// One Levinson-Durbin order step: walks j=1..i-1 through levinson_out, stages results, commits bank atomically.
// Optional: LEVINSON_SAT_EN saturates lo_temp instead of wrapping.
module levinson_update #(
  parameter int ORDER = 10,
  parameter int IW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  levinson_update_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_a   [1:ORDER];
  logic [31:0]   r_stg [1:ORDER];
  logic [31:0]   r_k;
  logic [IW-1:0] r_i, r_j;
  logic          r_busy, r_done, r_err;

  logic [IW-1:0]      w_ij;
  logic [31:0]        w_aj, w_aij, w_rd, w_temp;
  logic signed [63:0] w_prod, w_sh;
  logic               w_ord_ok;

  assign w_ij     = r_i - r_j;
  assign w_ord_ok = (bus.order_i != '0) && (bus.order_i <= IW'(ORDER));

  // Index 0 and indices above ORDER fall through to zero.
  always_comb begin
    w_aj  = '0;
    w_aij = '0;
    w_rd  = '0;
    for (int n = 1; n <= ORDER; n++) begin
      if (r_j == IW'(n))        w_aj  = r_a[n];
      if (w_ij == IW'(n))       w_aij = r_a[n];
      if (bus.rd_idx == IW'(n)) w_rd  = r_a[n];
    end
  end

  assign w_prod = $signed({{32{r_k[31]}}, r_k}) * $signed({{32{w_aij[31]}}, w_aij});
  assign w_sh   = w_prod >>> 29;

`ifdef LEVINSON_SAT_EN
  always_comb begin
    if (w_sh > 64'sd2147483647)       w_temp = 32'h7FFF_FFFF;
    else if (w_sh < -64'sd2147483648) w_temp = 32'h8000_0000;
    else                              w_temp = 32'(w_sh);
  end
`else
  assign w_temp = 32'(w_sh);
`endif

  assign bus.lo_out_sel = (r_state == S_RUN);
  assign bus.lo_temp    = (r_state == S_RUN) ? w_temp : '0;
  assign bus.lo_a       = (r_state == S_RUN) ? w_aj : '0;
  assign bus.lo_k       = (r_state == S_IDLE) ? '0 : r_k;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.rd_coef    = w_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int n = 1; n <= ORDER; n++) begin
        r_a[n]   <= '0;
        r_stg[n] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.clear) begin
            for (int n = 1; n <= ORDER; n++) r_a[n] <= '0;
          end else if (bus.start) begin
            if (w_ord_ok) begin
              r_k     <= bus.k;
              r_i     <= bus.order_i;
              r_j     <= IW'(1);
              r_busy  <= 1'b1;
              r_state <= (bus.order_i > IW'(1)) ? S_RUN : S_LAST;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Staging keeps the bank intact so a[i-j] reads stay on the old coefficients.
          for (int n = 1; n <= ORDER; n++)
            if (r_j == IW'(n)) r_stg[n] <= bus.lo_next_a;
          r_j <= r_j + 1'b1;
          if (r_j == r_i - 1'b1) r_state <= S_LAST;
        end
        S_LAST: begin
          for (int n = 1; n <= ORDER; n++) begin
            if (IW'(n) < r_i)       r_a[n] <= r_stg[n];
            else if (IW'(n) == r_i) r_a[n] <= bus.lo_next_a;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_levinson_update.sv
// Directed bench for levinson_update; includes a behavioural stand-in for the levinson_out stage.
`timescale 1ns/1ps
module tb_levinson_update;
  localparam int ORDER = 10;
  localparam int IW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          ncmp = 0;
  int          nmis = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  levinson_update_if #(.IW(IW)) bus();
  levinson_update #(.ORDER(ORDER), .IW(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // levinson_out stand-in: new a[i] = k/8, updated a[j] = a[j] + temp/4 (truncating)
  always_comb begin
    if (ovr_en)              bus.lo_next_a = ovr_val;
    else if (bus.lo_out_sel) bus.lo_next_a = bus.lo_a + 32'($signed(bus.lo_temp) / 4);
    else                     bus.lo_next_a = 32'($signed(bus.lo_k) / 8);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go(input logic [IW-1:0] ord, input logic [31:0] kk);
    bus.start = 1'b1; bus.order_i = ord; bus.k = kk;
    tick();
    bus.start = 1'b0; bus.order_i = '0; bus.k = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    ncmp++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL rst_busy got %0b want 0", bus.busy); end
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL rst_done got %0b want 0", bus.done); end
    ncmp++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL rst_err got %0b want 0", bus.err); end
    ncmp++; if (bus.lo_out_sel !== 1'b0) begin nmis++; $display("FAIL rst_sel got %0b want 0", bus.lo_out_sel); end
    ncmp++; if (bus.lo_temp !== 32'h0) begin nmis++; $display("FAIL rst_temp got %h want 0", bus.lo_temp); end
    ncmp++; if (bus.lo_a !== 32'h0) begin nmis++; $display("FAIL rst_a got %h want 0", bus.lo_a); end
    ncmp++; if (bus.lo_k !== 32'h0) begin nmis++; $display("FAIL rst_k got %h want 0", bus.lo_k); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL rst_coef1 got %h want 0", bus.rd_coef); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_order1();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    go(4'd1, 32'h1000_0000);
    ncmp++; if (bus.busy !== 1'b1) begin nmis++; $display("FAIL o1_busy got %0b want 1", bus.busy); end
    ncmp++; if (bus.lo_out_sel !== 1'b0) begin nmis++; $display("FAIL o1_sel got %0b want 0", bus.lo_out_sel); end
    ncmp++; if (bus.lo_k !== 32'h1000_0000) begin nmis++; $display("FAIL o1_k got %h want 10000000", bus.lo_k); end
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL o1_early_done got %0b want 0", bus.done); end
    tick();
    ncmp++; if (bus.done !== 1'b1) begin nmis++; $display("FAIL o1_done got %0b want 1", bus.done); end
    ncmp++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL o1_busy_end got %0b want 0", bus.busy); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'h0200_0000) begin nmis++; $display("FAIL o1_a1 got %h want 02000000", bus.rd_coef); end
  endtask

  // Issued in the done cycle of the previous step
  task automatic test_order2();
    go(4'd2, 32'h0800_0000);
    ncmp++; if (bus.lo_out_sel !== 1'b1) begin nmis++; $display("FAIL o2_sel got %0b want 1", bus.lo_out_sel); end
    ncmp++; if (bus.lo_temp !== 32'h0080_0000) begin nmis++; $display("FAIL o2_temp got %h want 00800000", bus.lo_temp); end
    ncmp++; if (bus.lo_a !== 32'h0200_0000) begin nmis++; $display("FAIL o2_lo_a got %h want 02000000", bus.lo_a); end
    bus.rd_idx = 4'd2; #1;
    ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL o2_old_a2 got %h want 0", bus.rd_coef); end
    tick();
    ncmp++; if (bus.lo_out_sel !== 1'b0) begin nmis++; $display("FAIL o2_last_sel got %0b want 0", bus.lo_out_sel); end
    ncmp++; if (bus.lo_temp !== 32'h0) begin nmis++; $display("FAIL o2_last_temp got %h want 0", bus.lo_temp); end
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL o2_early_done got %0b want 0", bus.done); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'h0200_0000) begin nmis++; $display("FAIL o2_old_a1 got %h want 02000000", bus.rd_coef); end
    tick();
    ncmp++; if (bus.done !== 1'b1) begin nmis++; $display("FAIL o2_done got %0b want 1", bus.done); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'h0220_0000) begin nmis++; $display("FAIL o2_a1 got %h want 02200000", bus.rd_coef); end
    bus.rd_idx = 4'd2; #1;
    ncmp++; if (bus.rd_coef !== 32'h0100_0000) begin nmis++; $display("FAIL o2_a2 got %h want 01000000", bus.rd_coef); end
  endtask

  // Back-to-back order 3 with start/clear/k churn while busy
  task automatic test_back_to_back();
    go(4'd3, 32'h1000_0000);
    bus.start = 1'b1; bus.clear = 1'b1; bus.k = 32'h7FFF_FFFF; bus.order_i = 4'd1;
    ncmp++; if (bus.lo_temp !== 32'h0080_0000) begin nmis++; $display("FAIL bb_temp1 got %h want 00800000", bus.lo_temp); end
    ncmp++; if (bus.lo_k !== 32'h1000_0000) begin nmis++; $display("FAIL bb_k got %h want 10000000", bus.lo_k); end
    tick();
    ncmp++; if (bus.lo_temp !== 32'h0110_0000) begin nmis++; $display("FAIL bb_temp2 got %h want 01100000", bus.lo_temp); end
    ncmp++; if (bus.busy !== 1'b1) begin nmis++; $display("FAIL bb_busy got %0b want 1", bus.busy); end
    tick();
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL bb_early_done got %0b want 0", bus.done); end
    bus.start = 1'b0; bus.clear = 1'b0; bus.k = '0; bus.order_i = '0;
    tick();
    ncmp++; if (bus.done !== 1'b1) begin nmis++; $display("FAIL bb_done got %0b want 1", bus.done); end
    ncmp++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL bb_busy_end got %0b want 0", bus.busy); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'h0240_0000) begin nmis++; $display("FAIL bb_a1 got %h want 02400000", bus.rd_coef); end
    bus.rd_idx = 4'd2; #1;
    ncmp++; if (bus.rd_coef !== 32'h0144_0000) begin nmis++; $display("FAIL bb_a2 got %h want 01440000", bus.rd_coef); end
    bus.rd_idx = 4'd3; #1;
    ncmp++; if (bus.rd_coef !== 32'h0200_0000) begin nmis++; $display("FAIL bb_a3 got %h want 02000000", bus.rd_coef); end
    bus.rd_idx = 4'd4; #1;
    ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL bb_a4 got %h want 0", bus.rd_coef); end
    bus.rd_idx = 4'd0; #1;
    ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL bb_idx0 got %h want 0", bus.rd_coef); end
    bus.rd_idx = 4'd11; #1;
    ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL bb_idx11 got %h want 0", bus.rd_coef); end
    tick();
  endtask

  task automatic test_negative();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    go(4'd1, 32'hFFFF_FFF7);
    tick();
    ncmp++; if (bus.done !== 1'b1) begin nmis++; $display("FAIL neg_done got %0b want 1", bus.done); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'hFFFF_FFFF) begin nmis++; $display("FAIL neg_a1 got %h want ffffffff", bus.rd_coef); end
    bus.rd_idx = 4'd3; #1;
    ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL neg_a3_cleared got %h want 0", bus.rd_coef); end
    tick();
  endtask

  task automatic test_invalid();
    go(4'd0, 32'h1000_0000);
    ncmp++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL inv0_err got %0b want 1", bus.err); end
    ncmp++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL inv0_busy got %0b want 0", bus.busy); end
    tick();
    ncmp++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL inv0_err_pulse got %0b want 0", bus.err); end
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL inv0_done got %0b want 0", bus.done); end
    go(4'd11, 32'h1000_0000);
    ncmp++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL inv11_err got %0b want 1", bus.err); end
    ncmp++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL inv11_busy got %0b want 0", bus.busy); end
    go(4'd15, 32'h1000_0000);
    ncmp++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL inv15_err got %0b want 1", bus.err); end
    tick();
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL inv_done got %0b want 0", bus.done); end
    bus.rd_idx = 4'd1; #1;
    ncmp++; if (bus.rd_coef !== 32'hFFFF_FFFF) begin nmis++; $display("FAIL inv_a1 got %h want ffffffff", bus.rd_coef); end
  endtask

  // Extreme products: saturating build clamps, default build wraps
  task automatic test_wide_product();
    logic [31:0] exp_pos, exp_neg;
`ifdef LEVINSON_SAT_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'hFFFF_FFF8; exp_neg = 32'h0000_0004;
`endif
    ovr_en = 1'b1; ovr_val = 32'h7FFF_FFFF;
    go(4'd1, 32'h0);
    tick();
    go(4'd2, 32'h7FFF_FFFF);
    ncmp++; if (bus.lo_a !== 32'h7FFF_FFFF) begin nmis++; $display("FAIL wide_lo_a got %h want 7fffffff", bus.lo_a); end
    ncmp++; if (bus.lo_temp !== exp_pos) begin nmis++; $display("FAIL wide_pos_temp got %h want %h", bus.lo_temp, exp_pos); end
    tick(); tick();
    go(4'd2, 32'h8000_0000);
    ncmp++; if (bus.lo_temp !== exp_neg) begin nmis++; $display("FAIL wide_neg_temp got %h want %h", bus.lo_temp, exp_neg); end
    tick(); tick();
    ncmp++; if (bus.done !== 1'b1) begin nmis++; $display("FAIL wide_done got %0b want 1", bus.done); end
    ovr_en = 1'b0;
    tick();
  endtask

  task automatic test_midreset();
    int bad;
    go(4'd4, 32'h1000_0000);
    ncmp++; if (bus.busy !== 1'b1) begin nmis++; $display("FAIL mr_busy got %0b want 1", bus.busy); end
    tick();
    rst_n = 1'b0;
    tick();
    ncmp++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL mr_busy_rst got %0b want 0", bus.busy); end
    ncmp++; if (bus.done !== 1'b0) begin nmis++; $display("FAIL mr_done_rst got %0b want 0", bus.done); end
    for (int n = 0; n < 16; n++) begin
      bus.rd_idx = 4'(n); #0.2;
      ncmp++; if (bus.rd_coef !== 32'h0) begin nmis++; $display("FAIL mr_coef%0d got %h want 0", n, bus.rd_coef); end
    end
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    ncmp++; if (bad !== 0) begin nmis++; $display("FAIL mr_no_done got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    bus.clear = 1'b0; bus.start = 1'b0; bus.order_i = '0; bus.k = '0; bus.rd_idx = '0;
    test_reset();
    test_order1();
    test_order2();
    test_back_to_back();
    test_negative();
    test_invalid();
    test_wide_product();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule

// File: doc/levinson_update.md
# levinson_update

Sequencer for one order step of the fixed-point Levinson-Durbin recursion in the LPC pipeline. It holds the predictor coefficient bank a[1..ORDER] and, for each order i, walks j = 1..i-1 to drive the `levinson_out` datapath stage. It forms the product term temp = k·a[i-j] for that stage, captures next_a and commits the updated bank atomically. Upstream, the reflection-coefficient stage supplies k and the order. Downstream, the bank is read out through a combinational read port.

## Interface
Parameters:
- ORDER, 10: maximum predictor order; the bank holds a[1..ORDER].
- IW, 4: width of order and index fields; must satisfy 2^IW > ORDER.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  zeroes a[1..ORDER]; accepted only in IDLE.
- start  in  1  begins an order step; sampled only in IDLE.
- order_i  in  IW  order i of the step (valid range 1..ORDER); sampled with start.
- k  in  32  signed reflection coefficient, Q3.28; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; the bank has been updated.
- err  out  1  one-cycle pulse; start carried an invalid order_i.
- lo_out_sel  out  1  to `levinson_out` out_sel: 1 = update a[j], 0 = new a[i].
- lo_temp  out  32  to `levinson_out` temp.
- lo_a  out  32  to `levinson_out` a, which is a[j].
- lo_k  out  32  to `levinson_out` k, which is the latched k.
- lo_next_a  in  32  from `levinson_out` next_a.
- rd_idx  in  IW  read index.
- rd_coef  out  32  combinational a[rd_idx]; reads 0 for idx 0 or idx > ORDER.

## Operation
- States: IDLE, RUN, LAST.
- IDLE:
  - clear=1 zeroes the bank.
  - start with order_i in 1..ORDER: latch k, latch i, set j=1, busy=1. Next state is RUN if i>1, otherwise LAST.
  - start with an invalid order_i (0 or >ORDER): pulse err next cycle; the bank is unchanged and the state stays IDLE.
  - clear and start in the same cycle: clear wins and start is dropped.
- RUN (one cycle per j, for j = 1..i-1):
  - lo_out_sel=1, lo_a=a[j].
  - lo_temp = the 64-bit signed product k·a[i-j], arithmetic-shifted right by 29, low 32 bits kept (wraps).
  - staging[j] <= lo_next_a.
  - j increments each cycle; when j reaches i-1, the next state is LAST.
- LAST:
  - lo_out_sel=0 and lo_temp=0.
  - a[1..i-1] <= staging[1..i-1] and a[i] <= lo_next_a, all on the same edge.
  - done <= 1, busy <= 0, next state IDLE.
- Reads of a[·] during RUN always see the old bank. The in-place hazard is removed by staging; coefficients above i are untouched.
- start, clear and a changing k/order_i are ignored while busy. The latched values are used.
- In IDLE, lo_* outputs are driven to 0 (lo_out_sel=0).

## Timing
- The start-sampling edge is edge 0.
- RUN occupies cycles 1..i-1 and LAST occupies cycle i. done is high during cycle i+1, and the new bank is visible on rd_coef in that same cycle.
- Latency is i+1 cycles from the start edge to done. The next start is accepted in the done cycle.
- err is high in cycle 1 after an invalid start.
- Reset values: busy=0, done=0, err=0, lo_out_sel=0, lo_temp=0, lo_a=0, lo_k=0, bank=0, staging=0, state IDLE.
- Reset mid-step aborts the step. The bank is zeroed, and no done is issued.
- The `levinson_out` path is purely combinational within the cycle; there are no extra pipeline stages.

## Configuration
- LEVINSON_SAT_EN defined: lo_temp saturates to 0x7FFF_FFFF or 0x8000_0000 when the shifted product exceeds the signed 32-bit range.
- LEVINSON_SAT_EN undefined: lo_temp takes the low 32 bits, two's-complement wrap.
- All other behaviour is identical in both builds.

## Test plan
- Reset, clear, then start order_i=1 with k=0x1000_0000 -> done in cycle 2, and rd_coef(1)=0x0200_0000.
- Continue with start order_i=2, k=0x0800_0000 -> a RUN cycle with lo_temp=0x0080_0000; done in cycle 3; a[1]=0x0220_0000 and a[2]=0x0100_0000.
- Clear, then order 1 with k=0xFFFF_FFF7 (-9) -> a[1]=0xFFFF_FFFF (round toward zero).
- start with order_i=0, then order_i=ORDER+1 -> err pulses each time, there is no busy/done, and the bank is unchanged.
- Assert start, clear and a new k during busy of an order-3 step -> all ignored; done in cycle 4 with the expected values.
- Drive rst_n low in cycle 2 of an order-4 step -> next cycle busy=0, no done, rd_coef=0 for every idx. With LEVINSON_SAT_EN, use k=0x7FFF_FFFF and a[i-j]=0x7FFF_FFFF -> lo_temp=0x7FFF_FFFF.
